// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter for the RV64IM core.
// Merges single-cycle ALU writebacks with MUL/DIV results parked in a 1-entry
// holding buffer, and tracks in-flight MUL/DIV destinations for decode hazards.
// Optional build macro: WB_ARB_FWD_EN adds write-cycle bypass outputs.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            md_valid,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_data,
  output logic            md_ready,
  input  logic            md_issue,
  input  logic [4:0]      md_issue_rd,
  input  logic [4:0]      q_r1,
  input  logic [4:0]      q_r2,
  input  logic [4:0]      q_rd,
  output logic            busy_r1,
  output logic            busy_r2,
  output logic            busy_rd,
`ifdef WB_ARB_FWD_EN
  output logic            fwd_r1_hit,
  output logic            fwd_r2_hit,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {StEmpty, StHeld} buf_state_e;

  buf_state_e      state_q, state_d;
  logic [4:0]      hold_rd_q, hold_rd_d;
  logic [XLEN-1:0] hold_data_q, hold_data_d;
  logic [3:0]      starve_q, starve_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_src_md_q, wb_src_md_d;
  // Bit 0 is never set, so a query of x0 always reads not-busy.
  logic [31:0]     pending_q, pending_d;

  logic md_grant;
  logic alu_grant;

  // Arbitration: a held result wins when the ALU is idle or it has starved long enough.
  always_comb begin
    md_grant  = (state_q == StHeld) && (!alu_valid || (starve_q == StarveMax));
    alu_grant = alu_valid && !md_grant;
    md_ready  = (state_q == StEmpty) || md_grant;
    alu_ready = !md_grant;
  end

  // Holding-buffer next state and starvation counter.
  always_comb begin
    state_d     = state_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    starve_d    = 4'd0;
    if (md_valid && md_ready) begin
      // Covers both a fresh load and a reload in the cycle the old result drains.
      state_d     = StHeld;
      hold_rd_d   = md_rd;
      hold_data_d = md_data;
    end else if (md_grant) begin
      state_d = StEmpty;
    end
    if ((state_q == StHeld) && !md_grant) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end
  end

  // Registered write port; x0 writes are granted but never raise the enable.
  always_comb begin
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_src_md_d = md_grant;
    if (md_grant) begin
      wb_we_d   = (hold_rd_q != 5'd0);
      wb_rd_d   = hold_rd_q;
      wb_data_d = hold_data_q;
    end else if (alu_grant) begin
      wb_we_d   = (alu_rd != 5'd0);
      wb_rd_d   = alu_rd;
      wb_data_d = alu_data;
    end
  end

  // Scoreboard: clear on a completed MUL/DIV write, then set on issue so a newer op wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_we_q && wb_src_md_q) begin
      pending_d[wb_rd_q] = 1'b0;
    end
    if (md_issue && (md_issue_rd != 5'd0)) begin
      pending_d[md_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StEmpty;
      hold_rd_q   <= 5'd0;
      hold_data_q <= '0;
      starve_q    <= 4'd0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      wb_src_md_q <= 1'b0;
      pending_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
      starve_q    <= starve_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_src_md_q <= wb_src_md_d;
      pending_q   <= pending_d;
    end
  end

  // Hazard queries and write-port outputs.
  always_comb begin
    busy_r1 = pending_q[q_r1];
    busy_r2 = pending_q[q_r2];
    busy_rd = pending_q[q_rd];
    wb_we   = wb_we_q;
    wb_rd   = wb_rd_q;
    wb_data = wb_data_q;
  end

`ifdef WB_ARB_FWD_EN
  // Bypass of the value being written this cycle.
  always_comb begin
    fwd_r1_hit = wb_we_q && (wb_rd_q == q_r1) && (q_r1 != 5'd0);
    fwd_r2_hit = wb_we_q && (wb_rd_q == q_r2) && (q_r2 != 5'd0);
    fwd_data   = wb_data_q;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [63:0] alu_data = '0;
  logic        alu_ready;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [63:0] md_data = '0;
  logic        md_ready;
  logic        md_issue = 1'b0;
  logic [4:0]  md_issue_rd = '0;
  logic [4:0]  q_r1 = '0, q_r2 = '0, q_rd = '0;
  logic        busy_r1, busy_r2, busy_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
`ifdef WB_ARB_FWD_EN
  logic        fwd_r1_hit, fwd_r2_hit;
  logic [63:0] fwd_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.XLEN(64), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .q_r1(q_r1), .q_r2(q_r2), .q_rd(q_rd),
    .busy_r1(busy_r1), .busy_r2(busy_r2), .busy_rd(busy_rd),
`ifdef WB_ARB_FWD_EN
    .fwd_r1_hit(fwd_r1_hit), .fwd_r2_hit(fwd_r2_hit), .fwd_data(fwd_data),
`endif
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a parked result, how long it has been losing, the set of
  // registers awaiting a MUL/DIV write, and the last write-port transaction.
  bit          m_held = 0;
  logic [4:0]  m_hrd = '0;
  logic [63:0] m_hdata = '0;
  int          m_lost = 0;
  bit          m_pend[32];
  bit          m_we = 0;
  bit          m_src_md = 0;
  logic [4:0]  m_rd = '0;
  logic [63:0] m_data = '0;

  function automatic bit md_wins();
    return m_held && (!alu_valid || m_lost >= LIMIT);
  endfunction

  function automatic bit exp_busy(input logic [4:0] q);
    return (q != 0) && m_pend[q];
  endfunction

  always @(negedge reset_n) begin
    m_held = 0; m_hrd = '0; m_hdata = '0; m_lost = 0;
    m_we = 0; m_src_md = 0; m_rd = '0; m_data = '0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      bit win;
      bit accept;
      win = md_wins();
      accept = md_valid && (!m_held || win);
      if (m_we && m_src_md) m_pend[m_rd] = 0;
      if (md_issue && md_issue_rd != 0) m_pend[md_issue_rd] = 1;
      if (win) begin
        m_we = (m_hrd != 0); m_rd = m_hrd; m_data = m_hdata; m_src_md = 1;
      end else if (alu_valid) begin
        m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data; m_src_md = 0;
      end else begin
        m_we = 0; m_src_md = 0;
      end
      m_lost = (m_held && !win) ? ((m_lost + 1 > LIMIT) ? LIMIT : m_lost + 1) : 0;
      if (accept) begin
        m_held = 1; m_hrd = md_rd; m_hdata = md_data;
      end else if (win) begin
        m_held = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      bit w;
      w = md_wins();
      check("alu_ready", 64'(alu_ready), 64'(!w));
      check("md_ready", 64'(md_ready), 64'(!m_held || w));
      check("busy_r1", 64'(busy_r1), 64'(exp_busy(q_r1)));
      check("busy_r2", 64'(busy_r2), 64'(exp_busy(q_r2)));
      check("busy_rd", 64'(busy_rd), 64'(exp_busy(q_rd)));
      check("wb_we", 64'(wb_we), 64'(m_we));
      check("wb_rd", 64'(wb_rd), 64'(m_rd));
      check("wb_data", wb_data, m_data);
`ifdef WB_ARB_FWD_EN
      check("fwd_r1_hit", 64'(fwd_r1_hit), 64'(m_we && m_rd == q_r1 && q_r1 != 0));
      check("fwd_r2_hit", 64'(fwd_r2_hit), 64'(m_we && m_rd == q_r2 && q_r2 != 0));
      check("fwd_data", fwd_data, m_data);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges, with immediate checks.
  task automatic mid_reset(input string tag);
    #1 reset_n = 1'b0;
    #1;
    check({tag, "_wb_we"}, 64'(wb_we), 64'd0);
    check({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
    check({tag, "_md_ready"}, 64'(md_ready), 64'd1);
    check({tag, "_alu_ready"}, 64'(alu_ready), 64'd1);
    check({tag, "_busy_rd"}, 64'(busy_rd), 64'd0);
    check({tag, "_busy_r1"}, 64'(busy_r1), 64'd0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    q_r1 = 5'd5; q_r2 = 5'd9; q_rd = 5'd31;
    #3;
    check("rst_wb_we", 64'(wb_we), 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_md_ready", 64'(md_ready), 64'd1);
    check("rst_busy", 64'({busy_r1, busy_r2, busy_rd}), 64'd0);
    #9 reset_n = 1'b1;

    // ALU only
    step();
    alu_valid = 1; alu_rd = 5'd1; alu_data = 64'd5;
    #1 check("alu_ready", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 0;
    #1;
    check("alu_wb_we", 64'(wb_we), 64'd1);
    check("alu_wb_rd", 64'(wb_rd), 64'd1);
    check("alu_wb_data", wb_data, 64'd5);

    // x0 suppression, ALU then MD path
    alu_valid = 1; alu_rd = 5'd0; alu_data = 64'hFF;
    #1 check("x0_alu_ready", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 0;
    #1 check("x0_alu_we", 64'(wb_we), 64'd0);
    md_valid = 1; md_rd = 5'd0; md_data = 64'hFF;
    #1 check("x0_md_ready", 64'(md_ready), 64'd1);
    step();
    md_valid = 0;
    #1 check("x0_md_drain", 64'(md_ready), 64'd1);
    step();
    check("x0_md_we", 64'(wb_we), 64'd0);

    // Scoreboard
    md_issue = 1; md_issue_rd = 5'd2;
    step();
    md_issue = 0; q_r1 = 5'd2;
    #1 check("sb_busy_set", 64'(busy_r1), 64'd1);
    md_valid = 1; md_rd = 5'd2; md_data = 64'd10;
    step();
    md_valid = 0;
    step();
    check("sb_wb_we", 64'(wb_we), 64'd1);
    check("sb_wb_rd", 64'(wb_rd), 64'd2);
    check("sb_wb_data", wb_data, 64'd10);
    check("sb_busy_still", 64'(busy_r1), 64'd1);
    step();
    check("sb_busy_clear", 64'(busy_r1), 64'd0);

    // Starvation
    md_valid = 1; md_rd = 5'd3; md_data = 64'd33;
    step();
    md_valid = 0; alu_valid = 1; alu_rd = 5'd4; alu_data = 64'd44;
    for (int i = 0; i < 3; i++) begin
      #1 check("starve_alu_wins", 64'(alu_ready), 64'd1);
      step();
    end
    #1 check("starve_forced", 64'(alu_ready), 64'd0);
    step();
    check("starve_wb_rd", 64'(wb_rd), 64'd3);
    check("starve_wb_data", wb_data, 64'd33);
    check("starve_alu_back", 64'(alu_ready), 64'd1);
    alu_valid = 0;

    // Back-to-back MD results
    md_valid = 1; md_rd = 5'd6; md_data = 64'd60;
    step();
    md_rd = 5'd7; md_data = 64'd70;
    #1 check("b2b_md_ready", 64'(md_ready), 64'd1);
    step();
    md_valid = 0;
    check("b2b_first", wb_data, 64'd60);
    step();
    check("b2b_second_rd", 64'(wb_rd), 64'd7);
    check("b2b_second", wb_data, 64'd70);

    // Reset mid-operation
    md_issue = 1; md_issue_rd = 5'd5; q_rd = 5'd5;
    step();
    md_issue = 0;
    md_valid = 1; md_rd = 5'd8; md_data = 64'd80;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 64'd90;
    step();
    md_valid = 0;
    #1;
    check("mid_md_ready_busy", 64'(md_ready), 64'd0);
    check("mid_busy_rd_set", 64'(busy_rd), 64'd1);
    alu_valid = 0;
    mid_reset("mid");
    step();
    check("mid_no_pulse", 64'(wb_we), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      alu_valid   = ($urandom_range(0, 9) < 6);
      alu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu_data    = {$urandom, $urandom};
      md_valid    = ($urandom_range(0, 9) < 4);
      md_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
      md_data     = {$urandom, $urandom};
      md_issue    = ($urandom_range(0, 9) < 3);
      md_issue_rd = 5'($urandom_range(0, 7));
      q_r1        = 5'($urandom_range(0, 7));
      q_r2        = 5'($urandom_range(0, 7));
      q_rd        = 5'($urandom);
      if ($urandom_range(0, 399) == 0) mid_reset("rnd_rst");
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
